// File: rtl/cheshire_rst_rtc_gen_if.sv
// Board reset inputs and generated SoC reset / RTC outputs of cheshire_rst_rtc_gen.
interface cheshire_rst_rtc_gen_if;
    logic       cpu_reset_i;
    logic       jtag_trst_ni;
    logic       soc_rst_no;
    logic       rtc_o;
    logic       rtc_tick_o;
    logic [1:0] rst_cause_o;

    modport master (
        output cpu_reset_i, jtag_trst_ni,
        input  soc_rst_no, rtc_o, rtc_tick_o, rst_cause_o
    );

    modport slave (
        input  cpu_reset_i, jtag_trst_ni,
        output soc_rst_no, rtc_o, rtc_tick_o, rst_cause_o
    );
endinterface

// File: rtl/cheshire_rst_rtc_gen.sv
// SoC reset sequencer (synchronize, debounce, stretch) with a free-running RTC divider
// and sticky reset-cause flags.
module cheshire_rst_rtc_gen #(
    parameter int unsigned ClkFreqHz      = 200000000,
    parameter int unsigned RtcFreqHz      = 1000000,
    parameter int unsigned SyncStages     = 2,
    parameter int unsigned DebounceCycles = 1024,
    parameter int unsigned StretchCycles  = 256
) (
    input logic                   clk_i,
    input logic                   rst_i,
    cheshire_rst_rtc_gen_if.slave bus
);
    localparam int unsigned Div    = ClkFreqHz / RtcFreqHz;
    localparam int unsigned Hi     = Div / 2;
    localparam int unsigned RcntW  = (Div > 2) ? $clog2(Div) : 1;
    localparam int unsigned MaxCnt = (DebounceCycles > StretchCycles) ? DebounceCycles : StretchCycles;
    localparam int unsigned CntW   = (MaxCnt > 2) ? $clog2(MaxCnt) : 1;

    localparam logic [CntW-1:0]  DebLast  = CntW'(DebounceCycles - 1);
    localparam logic [CntW-1:0]  StrLast  = CntW'(StretchCycles - 1);
    localparam logic [RcntW-1:0] RcntLast = RcntW'(Div - 1);
    localparam logic [RcntW-1:0] HiLast   = RcntW'(Hi - 1);

    if (Div < 2) begin : g_bad_div
        $error("cheshire_rst_rtc_gen: ClkFreqHz/RtcFreqHz must be at least 2");
    end
    if (SyncStages < 1) begin : g_bad_sync
        $error("cheshire_rst_rtc_gen: SyncStages must be at least 1");
    end
    if (DebounceCycles < 1 || StretchCycles < 1) begin : g_bad_cnt
        $error("cheshire_rst_rtc_gen: DebounceCycles and StretchCycles must be at least 1");
    end

    typedef enum logic [1:0] {HOLD, DEBOUNCE, STRETCH, RUN} state_e;

    logic [SyncStages-1:0] btn_sync, trst_sync;
    logic                  btn_s, trst_s, req_s;
    state_e                state, state_next;
    logic [CntW-1:0]       cnt, cnt_next;
    logic [1:0]            cause, cause_next;
    logic [RcntW-1:0]      rcnt;
    logic                  rtc, tick;

    // Reset preloads the chains so the request is asserted until real pin values arrive.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            btn_sync  <= '1;
            trst_sync <= '0;
        end else begin
            btn_sync[0]  <= bus.cpu_reset_i;
            trst_sync[0] <= bus.jtag_trst_ni;
            for (int i = 1; i < int'(SyncStages); i++) begin
                btn_sync[i]  <= btn_sync[i-1];
                trst_sync[i] <= trst_sync[i-1];
            end
        end
    end

    assign btn_s  = btn_sync[SyncStages-1];
    assign trst_s = trst_sync[SyncStages-1];
    assign req_s  = btn_s | ~trst_s;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cause_next = cause;
        if (req_s) begin
            // A request wins over any terminal count reached in the same cycle.
            state_next = HOLD;
            cnt_next   = '0;
            if (state != HOLD) begin
                cause_next = cause | {~trst_s, btn_s};
            end
        end else begin
            unique case (state)
                HOLD: begin
                    state_next = DEBOUNCE;
                    cnt_next   = '0;
                end
                DEBOUNCE: begin
                    if (cnt == DebLast) begin
                        state_next = STRETCH;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CntW'(1);
                    end
                end
                STRETCH: begin
                    if (cnt == StrLast) begin
                        state_next = RUN;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CntW'(1);
                    end
                end
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= HOLD;
            cnt   <= '0;
            cause <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            cause <= cause_next;
        end
    end

    // RTC divider runs regardless of the reset sequencer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rcnt <= '0;
            rtc  <= 1'b0;
            tick <= 1'b0;
        end else begin
            rcnt <= (rcnt == RcntLast) ? '0 : rcnt + RcntW'(1);
            tick <= (rcnt == RcntLast);
            if (rcnt == RcntLast) begin
                rtc <= 1'b1;
            end else if (rcnt == HiLast) begin
                rtc <= 1'b0;
            end
        end
    end

    assign bus.soc_rst_no  = (state == RUN);
    assign bus.rtc_o       = rtc;
    assign bus.rtc_tick_o  = tick;
    assign bus.rst_cause_o = cause;
endmodule
